// File: rtl/usbls_rx_pkt_check_pkg.sv
// Shared constants for the low-speed USB receive packet checker: PID codes,
// CRC16 parameters, FSM state encoding and PID classification helpers.
package usbls_rx_pkt_check_pkg;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE   = 16'hB001;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PID   = 3'd1,
    ST_DATA  = 3'd2,
    ST_HSK   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic logic pid_is_data(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  function automatic logic pid_is_hsk(input logic [3:0] pid);
    return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
  endfunction

endpackage

// File: rtl/usbls_rx_crc16.sv
// Combinational one-byte CRC16 update, reflected (LSB-first) form.
// One generate stage per wire bit, bit0 of byte_in enters first.
module usbls_rx_crc16
  import usbls_rx_pkt_check_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  for (genvar i = 0; i < 8; i++) begin : g_bit
    logic [15:0] c_prev;
    logic [15:0] c_next;
    logic        fb;

    if (i == 0) begin : g_first
      assign c_prev = crc_in;
    end else begin : g_rest
      assign c_prev = g_bit[i-1].c_next;
    end

    assign fb     = c_prev[0] ^ byte_in[i];
    assign c_next = {1'b0, c_prev[15:1]} ^ (fb ? CRC16_POLY_REFL : 16'h0000);
  end

  assign crc_out = g_bit[7].c_next;

endmodule

// File: rtl/usbls_rx_pkt_check.sv
// Receive packet checker: validates PID, length and CRC16, forwards DATA payload
// with the two CRC bytes stripped, and strobes one result per packet after EOP.
module usbls_rx_pkt_check
  import usbls_rx_pkt_check_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_active,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_err,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             pkt_done,
  output logic [3:0]       pkt_pid,
  output logic             pkt_ok,
  output logic             pid_err,
  output logic             crc_err,
  output logic             len_err,
  output logic             stuff_err,
  output logic [CNT_W-1:0] pkt_len
);

  // Byte counter carries one extra bit so pkt_len can saturate after the CRC is subtracted.
  localparam logic [CNT_W:0] CNT_TWO  = (CNT_W+1)'(2);
  localparam logic [CNT_W:0] CNT_MAXL = (CNT_W+1)'(MAX_LEN);
  localparam logic [CNT_W:0] LEN_SAT  = {1'b0, {CNT_W{1'b1}}};

  state_e           state_q, state_d;
  logic             act_q;
  logic [15:0]      crc_q, crc_d, crc_upd;
  logic [CNT_W:0]   cnt_q, cnt_d, payload;
  logic [7:0]       dl_new_q, dl_new_d, dl_old_q, dl_old_d;
  logic [1:0]       dl_cnt_q, dl_cnt_d;
  logic [3:0]       pid_q, pid_d;
  logic             hsk_extra_q, hsk_extra_d;
  logic             stuff_q, stuff_d;
  logic             rise, start, eop;

  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             done_q, done_d;
  logic [3:0]       pkt_pid_q, pkt_pid_d;
  logic             pkt_ok_q, pkt_ok_d;
  logic             pid_err_q, pid_err_d;
  logic             crc_err_q, crc_err_d;
  logic             len_err_q, len_err_d;
  logic             stuff_err_q, stuff_err_d;
  logic [CNT_W-1:0] pkt_len_q, pkt_len_d;

  assign rise = rx_active & ~act_q;

  usbls_rx_crc16 u_crc16 (
    .crc_in  (crc_q),
    .byte_in (rx_data),
    .crc_out (crc_upd)
  );

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    dl_new_d    = dl_new_q;
    dl_old_d    = dl_old_q;
    dl_cnt_d    = dl_cnt_q;
    pid_d       = pid_q;
    hsk_extra_d = hsk_extra_q;
    stuff_d     = stuff_q;
    start       = 1'b0;
    eop         = 1'b0;
    payload     = '0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    pkt_pid_d   = pkt_pid_q;
    pkt_ok_d    = pkt_ok_q;
    pid_err_d   = pid_err_q;
    crc_err_d   = crc_err_q;
    len_err_d   = len_err_q;
    stuff_err_d = stuff_err_q;
    pkt_len_d   = pkt_len_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          start   = 1'b1;
          state_d = ST_PID;
        end
      end
      ST_PID: begin
        stuff_d = stuff_q | rx_err;
        if (rx_valid) begin
          pid_d = rx_data[3:0];
          if (rx_data[7:4] != ~rx_data[3:0]) state_d = ST_DRAIN;
          else if (pid_is_data(rx_data[3:0])) state_d = ST_DATA;
          else if (pid_is_hsk(rx_data[3:0]))  state_d = ST_HSK;
          else                                state_d = ST_DRAIN;
        end
        eop = ~rx_active;
      end
      ST_DATA: begin
        stuff_d = stuff_q | rx_err;
        if (rx_valid) begin
          crc_d = crc_upd;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          // A byte leaves the delay line only once two newer bytes sit behind it.
          if (dl_cnt_q == 2'd2) begin
            out_valid_d = 1'b1;
            out_data_d  = dl_old_q;
          end
          dl_old_d = dl_new_q;
          dl_new_d = rx_data;
          dl_cnt_d = (dl_cnt_q == 2'd2) ? 2'd2 : dl_cnt_q + 2'd1;
        end
        eop = ~rx_active;
      end
      ST_HSK: begin
        stuff_d = stuff_q | rx_err;
        if (rx_valid) hsk_extra_d = 1'b1;
        eop = ~rx_active;
      end
      ST_DRAIN: begin
        stuff_d = stuff_q | rx_err;
        eop     = ~rx_active;
      end
      ST_DONE: begin
        if (rise) begin
          start   = 1'b1;
          state_d = ST_PID;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      crc_d       = CRC16_INIT;
      cnt_d       = '0;
      dl_cnt_d    = 2'd0;
      pid_d       = 4'd0;
      hsk_extra_d = 1'b0;
      stuff_d     = 1'b0;
    end

    // state_d still names the packet class here, after this cycle's byte.
    if (eop) begin
      pid_err_d = 1'b0;
      crc_err_d = 1'b0;
      len_err_d = 1'b0;
      pkt_len_d = '0;
      case (state_d)
        ST_PID:   len_err_d = 1'b1;
        ST_DRAIN: pid_err_d = 1'b1;
        ST_HSK:   len_err_d = hsk_extra_d;
        ST_DATA: begin
          if (cnt_d < CNT_TWO) begin
            len_err_d = 1'b1;
          end else begin
            payload   = cnt_d - CNT_TWO;
            len_err_d = payload > CNT_MAXL;
            crc_err_d = crc_d != CRC16_RESIDUE;
            pkt_len_d = (payload > LEN_SAT) ? {CNT_W{1'b1}} : payload[CNT_W-1:0];
          end
        end
        default: ;
      endcase
      stuff_err_d = stuff_d;
      pkt_ok_d    = ~(pid_err_d | crc_err_d | len_err_d | stuff_d);
      pkt_pid_d   = pid_d;
      done_d      = 1'b1;
      state_d     = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      act_q       <= 1'b0;
      crc_q       <= CRC16_INIT;
      cnt_q       <= '0;
      dl_new_q    <= 8'd0;
      dl_old_q    <= 8'd0;
      dl_cnt_q    <= 2'd0;
      pid_q       <= 4'd0;
      hsk_extra_q <= 1'b0;
      stuff_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      done_q      <= 1'b0;
      pkt_pid_q   <= 4'd0;
      pkt_ok_q    <= 1'b0;
      pid_err_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      stuff_err_q <= 1'b0;
      pkt_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= rx_active;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      dl_new_q    <= dl_new_d;
      dl_old_q    <= dl_old_d;
      dl_cnt_q    <= dl_cnt_d;
      pid_q       <= pid_d;
      hsk_extra_q <= hsk_extra_d;
      stuff_q     <= stuff_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      pkt_pid_q   <= pkt_pid_d;
      pkt_ok_q    <= pkt_ok_d;
      pid_err_q   <= pid_err_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      stuff_err_q <= stuff_err_d;
      pkt_len_q   <= pkt_len_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pkt_done  = done_q;
  assign pkt_pid   = pkt_pid_q;
  assign pkt_ok    = pkt_ok_q;
  assign pid_err   = pid_err_q;
  assign crc_err   = crc_err_q;
  assign len_err   = len_err_q;
  assign stuff_err = stuff_err_q;
  assign pkt_len   = pkt_len_q;

endmodule

// File: tb/tb_usbls_rx_pkt_check.sv
// Bench for usbls_rx_pkt_check: two instances (MAX_LEN 8 and 16) share one stimulus
// stream; results are compared with a packet-level reference model.
module tb_usbls_rx_pkt_check;

  typedef logic [7:0] byte_q_t [$];
  typedef struct packed {
    logic [3:0]  pid;
    logic        ok, pe, ce, le, se;
    logic [31:0] len;
  } exp_t;

  logic       clk, rst_n, rx_active, rx_valid, rx_err;
  logic [7:0] rx_data;

  logic       out_valid_a, pkt_done_a, pkt_ok_a, pid_err_a, crc_err_a, len_err_a, stuff_err_a;
  logic [7:0] out_data_a;
  logic [3:0] pkt_pid_a, pkt_len_a;
  logic       out_valid_b, pkt_done_b, pkt_ok_b, pid_err_b, crc_err_b, len_err_b, stuff_err_b;
  logic [7:0] out_data_b;
  logic [3:0] pkt_pid_b;
  logic [4:0] pkt_len_b;

  int checks = 0, errors = 0, pkts = 0, done_a = 0, done_b = 0;
  byte_q_t q_a, q_b;
  logic [7:0] pid_tab [8];

  usbls_rx_pkt_check #(.MAX_LEN(8), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_active(rx_active), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_err(rx_err), .out_valid(out_valid_a), .out_data(out_data_a), .pkt_done(pkt_done_a),
    .pkt_pid(pkt_pid_a), .pkt_ok(pkt_ok_a), .pid_err(pid_err_a), .crc_err(crc_err_a),
    .len_err(len_err_a), .stuff_err(stuff_err_a), .pkt_len(pkt_len_a));

  usbls_rx_pkt_check #(.MAX_LEN(16), .CNT_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_active(rx_active), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_err(rx_err), .out_valid(out_valid_b), .out_data(out_data_b), .pkt_done(pkt_done_b),
    .pkt_pid(pkt_pid_b), .pkt_ok(pkt_ok_b), .pid_err(pid_err_b), .crc_err(crc_err_b),
    .len_err(len_err_b), .stuff_err(stuff_err_b), .pkt_len(pkt_len_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid_a) q_a.push_back(out_data_a);
    if (out_valid_b) q_b.push_back(out_data_b);
    if (pkt_done_a) done_a++;
    if (pkt_done_b) done_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] crc16(input byte_q_t b, input int first, input int last);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = first; k <= last; k++)
      for (int i = 0; i < 8; i++)
        c = (c[0] ^ b[k][i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  function automatic byte_q_t mk(input logic [127:0] v, input int n);
    byte_q_t o;
    o = {};
    for (int k = 0; k < n; k++) o.push_back(v[8*(n-1-k) +: 8]);
    return o;
  endfunction

  // Packet-level rules: PID class, length limits, CRC appended as ~crc(payload) low byte first.
  function automatic exp_t model(input byte_q_t b, input int max_len, input int cnt_w, input bit err);
    exp_t e;
    int n, pay, lim;
    logic [3:0] p;
    logic [15:0] want;
    e = '0;
    e.se = err;
    n = b.size();
    if (n == 0) begin
      e.le = 1'b1;
    end else begin
      p = b[0][3:0];
      e.pid = p;
      if (b[0][7:4] != ~p || !(p == 4'h3 || p == 4'hB || p == 4'h2 || p == 4'hA || p == 4'hE)) begin
        e.pe = 1'b1;
      end else if (p != 4'h3 && p != 4'hB) begin
        e.le = (n != 1);
      end else if (n < 3) begin
        e.le = 1'b1;
      end else begin
        pay  = n - 3;
        lim  = (1 << cnt_w) - 1;
        want = ~crc16(b, 1, n - 3);
        e.le = pay > max_len;
        e.ce = {b[n-1], b[n-2]} != want;
        e.len = (pay > lim) ? lim : pay;
      end
    end
    e.ok = !(e.pe | e.ce | e.le | e.se);
    return e;
  endfunction

  function automatic byte_q_t exp_out(input byte_q_t b);
    byte_q_t o;
    o = {};
    if (b.size() >= 3 && b[0][7:4] == ~b[0][3:0] && (b[0][3:0] == 4'h3 || b[0][3:0] == 4'hB))
      for (int k = 1; k < b.size() - 2; k++) o.push_back(b[k]);
    return o;
  endfunction

  task automatic chk_res(input string tag, input logic [3:0] pid, input logic ok, input logic pe,
                         input logic ce, input logic le, input logic se, input int len, input exp_t e);
    chk({tag, ".pid"}, 32'(pid), 32'(e.pid));
    chk({tag, ".ok"}, 32'(ok), 32'(e.ok));
    chk({tag, ".pid_err"}, 32'(pe), 32'(e.pe));
    chk({tag, ".crc_err"}, 32'(ce), 32'(e.ce));
    chk({tag, ".len_err"}, 32'(le), 32'(e.le));
    chk({tag, ".stuff_err"}, 32'(se), 32'(e.se));
    chk({tag, ".len"}, 32'(len), e.len);
  endtask

  task automatic run_pkt(input string tag, input byte_q_t b, input int err_idx, input bit coinc,
                         input bit rerise);
    exp_t ea, eb;
    byte_q_t eo;
    ea = model(b, 8, 4, err_idx >= 0);
    eb = model(b, 16, 5, err_idx >= 0);
    eo = exp_out(b);
    pkts++;
    if (!rx_active) begin
      @(posedge clk); #1;
      rx_active = 1'b1;
    end
    repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    foreach (b[k]) begin
      rx_valid = 1'b1;
      rx_data  = b[k];
      rx_err   = (k == err_idx);
      if (!(coinc && k == b.size() - 1)) begin
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    rx_active = 1'b0;
    @(negedge clk);
    chk({tag, ".early_done_a"}, 32'(pkt_done_a), 32'd0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    if (rerise) rx_active = 1'b1;
    @(negedge clk);
    chk({tag, ".done_a"}, 32'(pkt_done_a), 32'd1);
    chk({tag, ".done_b"}, 32'(pkt_done_b), 32'd1);
    chk_res({tag, "_a"}, pkt_pid_a, pkt_ok_a, pid_err_a, crc_err_a, len_err_a, stuff_err_a,
            int'(pkt_len_a), ea);
    chk_res({tag, "_b"}, pkt_pid_b, pkt_ok_b, pid_err_b, crc_err_b, len_err_b, stuff_err_b,
            int'(pkt_len_b), eb);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".done_pulse_a"}, 32'(pkt_done_a), 32'd0);
    chk({tag, ".held_pid_a"}, 32'(pkt_pid_a), 32'(ea.pid));
    chk({tag, ".ndone_a"}, done_a, pkts);
    chk({tag, ".ndone_b"}, done_b, pkts);
    chk({tag, ".nout_a"}, q_a.size(), eo.size());
    chk({tag, ".nout_b"}, q_b.size(), eo.size());
    foreach (eo[i]) begin
      if (i < q_a.size()) chk({tag, ".out_a"}, 32'(q_a[i]), 32'(eo[i]));
      if (i < q_b.size()) chk({tag, ".out_b"}, 32'(q_b[i]), 32'(eo[i]));
    end
    q_a = {};
    q_b = {};
  endtask

  initial begin
    byte_q_t rb;
    int sel, plen, ei;
    logic [15:0] cb;

    pid_tab = '{8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E, 8'hE1, 8'hD3, 8'h69};
    rst_n = 1'b0; rx_active = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", {out_valid_a, out_data_a, pkt_done_a, pkt_pid_a, pkt_ok_a, pid_err_a, crc_err_a,
                    len_err_a, stuff_err_a, pkt_len_a}, 32'd0);
    chk("reset_b", {out_valid_b, out_data_b, pkt_done_b, pkt_pid_b, pkt_ok_b, pid_err_b, crc_err_b,
                    len_err_b, stuff_err_b, pkt_len_b}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // A stray strobe while idle must not start or report anything.
    rx_valid = 1'b1; rx_data = 8'hC3;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_strobe_done", done_a, 0);
    chk("idle_strobe_out", q_a.size(), 0);

    run_pkt("ack", mk(128'hD2, 1), -1, 0, 0);
    run_pkt("zlp", mk(128'hC3_00_00, 3), -1, 0, 0);
    run_pkt("data1", mk(128'h4B_31_32_33_34_35_36_37_38_39_C8_B4, 12), -1, 0, 0);
    run_pkt("data1_bad", mk(128'h4B_31_32_33_34_35_36_37_38_39_C8_B5, 12), -1, 1, 0);
    run_pkt("pid_chk", mk(128'hD3, 1), -1, 0, 0);
    run_pkt("pid_type", mk(128'hE1, 1), -1, 1, 0);
    run_pkt("ack_extra", mk(128'hD2_55, 2), -1, 0, 0);
    run_pkt("data_short", mk(128'hC3_00, 2), -1, 0, 0);
    run_pkt("no_byte", mk(128'h0, 0), -1, 0, 0);
    run_pkt("b2b_1", mk(128'h5A, 1), -1, 1, 1);
    run_pkt("b2b_2", mk(128'hC3_00_00, 3), -1, 0, 1);
    run_pkt("b2b_3", mk(128'h1E, 1), -1, 0, 0);
    run_pkt("stuff", mk(128'hC3_31_32_33_34_35_36_37_38_39_C8_B4, 12), 5, 0, 0);

    // Abort mid-packet: flags from the last packet are nonzero, so a clear is visible.
    @(posedge clk); #1;
    rx_active = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      rx_valid = 1'b1;
      rx_data  = (k == 0) ? 8'hC3 : 8'hA5;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_a", {out_valid_a, out_data_a, pkt_done_a, pkt_pid_a, pkt_ok_a, pid_err_a, crc_err_a,
                    len_err_a, stuff_err_a, pkt_len_a}, 32'd0);
    chk("abort_b", {out_valid_b, out_data_b, pkt_done_b, pkt_pid_b, pkt_ok_b, pid_err_b, crc_err_b,
                    len_err_b, stuff_err_b, pkt_len_b}, 32'd0);
    rx_active = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_ndone_a", done_a, pkts);
    chk("abort_ndone_b", done_b, pkts);
    q_a = {};
    q_b = {};

    for (int p = 0; p < 40; p++) begin
      rb = {};
      sel = int'($urandom_range(0, 7));
      rb.push_back(pid_tab[sel]);
      if (sel < 2) begin
        if ($urandom_range(0, 9) == 0) begin
          repeat ($urandom_range(0, 1)) rb.push_back(8'($urandom));
        end else begin
          plen = int'($urandom_range(0, 18));
          repeat (plen) rb.push_back(8'($urandom));
          cb = ~crc16(rb, 1, rb.size() - 1);
          rb.push_back(cb[7:0]);
          rb.push_back(cb[15:8]);
          if ($urandom_range(0, 4) == 0)
            rb[rb.size()-1] = rb[rb.size()-1] ^ (8'h01 << $urandom_range(0, 7));
        end
      end else if (sel < 5) begin
        if ($urandom_range(0, 3) == 0) rb.push_back(8'($urandom));
      end else begin
        repeat ($urandom_range(0, 3)) rb.push_back(8'($urandom));
      end
      ei = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, rb.size() - 1)) : -1;
      run_pkt($sformatf("rnd%0d", p), rb, ei, $urandom_range(0, 2) == 0,
              (p < 39) && ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usbls_rx_pkt_check.md
Name: usbls_rx_pkt_check

Overview:
- Receive-side packet checker for the low-speed USB host; counterpart of the TX token CRC5 generator.
- Takes the byte stream from the RX NRZI/de-stuff/deserializer (SYNC already stripped) and validates the PID and the packet length.
- Computes and checks CRC16 over DATA0/DATA1 payloads.
- Forwards payload bytes with the CRC bytes removed, then reports one result strobe per packet to the host transaction FSM.

Parameters:
- MAX_LEN, 8, maximum data payload bytes accepted (low-speed limit); CRC bytes are not counted.
- CNT_W, 4, width of the payload byte counter; must hold MAX_LEN+2.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- rx_active  in  1  high from the first byte after SYNC until EOP; the falling edge marks end of packet.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte, bit0 = first bit on the wire.
- rx_err  in  1  bit-stuff or line error from the deserializer; sticky within the packet.
- out_valid  out  1  payload byte strobe.
- out_data  out  8  payload byte.
- pkt_done  out  1  one-cycle strobe, packet result valid.
- pkt_pid  out  4  PID[3:0] of the packet, held until the next pkt_done.
- pkt_ok  out  1  high with pkt_done when no error flag is set.
- pid_err  out  1  PID check nibble mismatch, or PID not DATA0/DATA1/ACK/NAK/STALL.
- crc_err  out  1  CRC16 residual mismatch.
- len_err  out  1  handshake packet not exactly 1 byte; data packet payload < 0 or > MAX_LEN.
- stuff_err  out  1  rx_err seen during the packet.
- pkt_len  out  CNT_W  payload byte count (0 for handshakes).

Behaviour:
- Reset: all outputs 0; FSM in IDLE; CRC register 16'hFFFF; delay line empty.
- FSM states and transitions:
  - IDLE -> PID on rx_active rising.
  - PID: first rx_valid latches the PID. rx_data[7:4] must equal ~rx_data[3:0], else pid_err.
  - PID -> DATA for PIDs 4'b0011 / 4'b1011.
  - PID -> HSK for 4'b0010 / 4'b1010 / 4'b1110.
  - Any other PID: set pid_err, go to DRAIN.
  - DATA, HSK, DRAIN -> DONE on rx_active falling.
  - DONE: assert pkt_done for 1 cycle, -> IDLE.
  - PID -> DONE if rx_active falls with no byte received (len_err, pkt_pid = 0).
- CRC16:
  - Reflected update, LSB-first, polynomial 16'hA001, init 16'hFFFF.
  - Every byte after the PID is fed, including both CRC bytes.
  - Good packet iff the register equals 16'hB001 at EOP.
  - The check is only meaningful with ≥ 2 bytes after the PID; otherwise len_err, and crc_err stays 0.
- CRC stripping:
  - Two-entry byte delay line. A byte is emitted on out_valid only when a third byte arrives, so out_data lags by two bytes.
  - The last two bytes are never emitted.
  - out_valid is registered, 1 cycle after the rx_valid that pushes the byte out.
- Payload bytes are still forwarded when count > MAX_LEN; len_err is flagged at EOP. Consumers discard the payload on !pkt_ok.
- pkt_len saturates at the all-ones value of CNT_W.
- HSK: a second byte sets len_err. No CRC check; nothing is output.
- rx_err at any point sets stuff_err. The packet still runs to EOP.
- pkt_done latency: exactly 1 cycle after the cycle rx_active is sampled low. Flags and pkt_pid are valid in the same cycle and held afterwards.
- rx_valid coincident with the rx_active fall: the byte is processed before EOP evaluation.
- rx_active rising while in DONE: the new packet is accepted; the FSM enters PID the next cycle and no byte is lost, because the first rx_valid is at least 1 cycle after the rise.
- rx_valid while in IDLE: ignored.
- Reset asserted mid-packet: immediate return to reset state; no pkt_done for the aborted packet.

Decomposition:
- Shared package/include holds:
  - PID constants: PID_DATA0 = 4'b0011, PID_DATA1 = 4'b1011, PID_ACK = 4'b0010, PID_NAK = 4'b1010, PID_STALL = 4'b1110.
  - CRC16_POLY_REFL = 16'hA001, CRC16_INIT = 16'hFFFF, CRC16_RESIDUE = 16'hB001.
  - FSM state encodings.
- One sub-module, usbls_rx_crc16: combinational 8-bit CRC16 update (crc_in, byte_in -> crc_out), same generate-loop style as the TX CRC5 generator.

Test Plan:
- ACK: bytes D2 then EOP -> pkt_done 1 cycle after EOP, pkt_pid = 2, pkt_ok = 1, pkt_len = 0, no out_valid.
- Zero-length DATA0: C3 00 00 -> pkt_ok = 1, pkt_len = 0, no out_valid.
- DATA1 with MAX_LEN = 16: 4B 31 32 33 34 35 36 37 38 39 C8 B4 -> 9 out_valid bytes 31..39 in order, pkt_ok = 1, pkt_len = 9. Flip the final byte to B5 -> crc_err = 1, pkt_ok = 0.
- Bad PID: D3 -> pid_err = 1; PID 4'b0001 with valid check (E1) -> pid_err = 1. Both complete with pkt_done.
- Length: ACK followed by an extra byte, DATA0 with 1 byte after the PID, and a 9-byte payload at MAX_LEN = 8 -> each gives len_err = 1.
- rx_err pulsed mid-DATA0 -> stuff_err = 1. Reset asserted mid-packet -> outputs 0 at once, no pkt_done. Back-to-back packets (rx_active re-rises in DONE) -> both reported.
